aer_ttfs_accumulator: RTL

AER_TTFS_ACCUMULATOR -- requirements
Module: aer_ttfs_accumulator

---
 rtl/aer_ttfs_accumulator_if.sv | 36 +++
 rtl/aer_ttfs_accumulator.sv | 138 +++++++++++++
 2 files changed

// File: rtl/aer_ttfs_accumulator_if.sv
`default_nettype none
// aer_ttfs_accumulator_if: event request, weight write, result stream and frame-done
// signals of the TTFS accumulator, bundled with master (driver) and slave (core) views.
interface aer_ttfs_accumulator_if #(
   parameter int NUM_INPUTS  = 64,
   parameter int NUM_OUTPUTS = 16,
   parameter int DATA_W      = 32,
   parameter int W_W         = 16
);
   logic                                           i_req;
   logic                                           o_ack;
   logic                                           i_req_type;
   logic signed [DATA_W-1:0]                       i_spike_time;
   logic [$clog2(NUM_INPUTS)-1:0]                  i_spike_addr;
   logic                                           i_w_we;
   logic [$clog2(NUM_INPUTS*NUM_OUTPUTS)-1:0]      i_w_addr;
   logic signed [W_W-1:0]                          i_w_data;
   logic                                           o_out_valid;
   logic signed [DATA_W-1:0]                       o_out_data;
   logic                                           o_out_last;
   logic                                           i_out_ready;
   logic                                           o_done;

   modport master (
      output i_req, i_req_type, i_spike_time, i_spike_addr,
      output i_w_we, i_w_addr, i_w_data, i_out_ready,
      input  o_ack, o_out_valid, o_out_data, o_out_last, o_done
   );

   modport slave (
      input  i_req, i_req_type, i_spike_time, i_spike_addr,
      input  i_w_we, i_w_addr, i_w_data, i_out_ready,
      output o_ack, o_out_valid, o_out_data, o_out_last, o_done
   );
endinterface
`default_nettype wire

// File: rtl/aer_ttfs_accumulator.sv
`default_nettype none
// aer_ttfs_accumulator: accumulates weight * (T_REF - spike time) per output neuron for each
// AER data event, then streams saturated results on an end-of-frame event.
module aer_ttfs_accumulator #(
   parameter int                        NUM_INPUTS  = 64,
   parameter int                        NUM_OUTPUTS = 16,
   parameter int                        DATA_W      = 32,
   parameter int                        W_W         = 16,
   parameter int                        ACC_W       = 48,
   parameter logic signed [DATA_W-1:0]  T_REF       = 32'sd1024
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_clk_enable,
   aer_ttfs_accumulator_if.slave        bus
);
   localparam int AW_IN  = $clog2(NUM_INPUTS);
   localparam int AW_OUT = $clog2(NUM_OUTPUTS);
   localparam int P_W    = W_W + DATA_W;
   localparam logic [AW_OUT-1:0]        LAST_IDX = AW_OUT'(NUM_OUTPUTS - 1);
   localparam logic signed [ACC_W-1:0]  ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0]  ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic signed [DATA_W-1:0] D_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] D_MIN    = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCUM  = 2'd1,
      S_OUTPUT = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                   state;
   logic [AW_OUT-1:0]        out_idx;
   logic [AW_OUT-1:0]        k;
   logic signed [DATA_W-1:0] lat_time;
   logic [AW_IN-1:0]         lat_addr;
   logic signed [ACC_W-1:0]  acc  [NUM_OUTPUTS];
   logic signed [W_W-1:0]    wmem [NUM_INPUTS*NUM_OUTPUTS];

   logic [DATA_W:0]          diff;
   logic signed [DATA_W-1:0] delta;
   logic signed [W_W-1:0]    w_rd;
   logic signed [P_W-1:0]    prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  acc_cur;
   logic [ACC_W:0]           sum;
   logic signed [ACC_W-1:0]  acc_next;
   logic signed [ACC_W-1:0]  acc_k;
   logic signed [DATA_W-1:0] acc_k_sat;

   always_comb begin
      // One extra bit keeps the time difference exact before clamping.
      diff = {T_REF[DATA_W-1], T_REF} - {lat_time[DATA_W-1], lat_time};
      if (diff[DATA_W])
         delta = '0;
      else if (diff[DATA_W-1])
         delta = D_MAX;
      else
         delta = diff[DATA_W-1:0];

      w_rd     = wmem[{lat_addr, out_idx}];
      prod     = P_W'(w_rd) * P_W'(delta);
      prod_ext = ACC_W'(prod);
      acc_cur  = acc[out_idx];
      sum      = {acc_cur[ACC_W-1], acc_cur} + {prod_ext[ACC_W-1], prod_ext};
      if (sum[ACC_W] != sum[ACC_W-1])
         acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      else
         acc_next = sum[ACC_W-1:0];

      acc_k = acc[k];
      if (acc_k > ACC_W'(D_MAX))
         acc_k_sat = D_MAX;
      else if (acc_k < ACC_W'(D_MIN))
         acc_k_sat = D_MIN;
      else
         acc_k_sat = DATA_W'(acc_k);
   end

   // Weight memory is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (i_clk_enable && (state == S_IDLE) && bus.i_w_we)
         wmem[bus.i_w_addr] <= bus.i_w_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         out_idx  <= '0;
         k        <= '0;
         lat_time <= '0;
         lat_addr <= '0;
         for (int j = 0; j < NUM_OUTPUTS; j++)
            acc[j] <= '0;
      end else if (i_clk_enable) begin
         case (state)
            S_IDLE: begin
               if (bus.i_req) begin
                  lat_time <= bus.i_spike_time;
                  lat_addr <= bus.i_spike_addr;
                  out_idx  <= '0;
                  state    <= bus.i_req_type ? S_OUTPUT : S_ACCUM;
               end
            end
            S_ACCUM: begin
               acc[out_idx] <= acc_next;
               if (out_idx == LAST_IDX) begin
                  out_idx <= '0;
                  state   <= S_IDLE;
               end else begin
                  out_idx <= out_idx + AW_OUT'(1);
               end
            end
            S_OUTPUT: begin
               if (bus.i_out_ready) begin
                  acc[k] <= '0;
                  if (k == LAST_IDX) begin
                     k     <= '0;
                     state <= S_DONE;
                  end else begin
                     k <= k + AW_OUT'(1);
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_ack       = rst_n && (state == S_IDLE) && bus.i_req && i_clk_enable;
   assign bus.o_out_valid = (state == S_OUTPUT);
   assign bus.o_out_last  = (state == S_OUTPUT) && (k == LAST_IDX);
   assign bus.o_out_data  = (state == S_OUTPUT) ? acc_k_sat : '0;
   assign bus.o_done      = (state == S_DONE) && i_clk_enable;
endmodule
`default_nettype wire
